// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: host command link endpoint. Receives 16-bit commands as
// two 8N1 UART bytes on RX, hands them to the consumer with a cmd_rdy level, and
// serialises 8-bit responses back on TX. RX and TX run independently.
module uart_cmd_responder #(
    parameter int BAUD_DIV = 3472
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO}                    asm_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic rx_meta, rx_sync, rx_prev;

    rx_state_t   rx_state, rx_next;
    logic [CW-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]  rx_bit, rx_bit_next;
    logic [7:0]  rx_shift, rx_shift_next;
    logic        rx_ferr, rx_ferr_next;
    logic        byte_done, frame_err;

    asm_state_t  asm_state, asm_next;

    tx_state_t   tx_state, tx_next;
    logic [CW-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]  tx_bit, tx_bit_next;
    logic [7:0]  tx_data, tx_data_next;
    logic        tx_line_next;

    // Two-flop synchroniser for RX plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
            rx_ferr  <= rx_ferr_next;
        end
    end

    // RX next-state logic: mid-bit sampling timed from the start edge
    always_comb begin
        rx_next       = rx_state;
        rx_cnt_next   = rx_cnt + CW'(1);
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_ferr_next  = rx_ferr;
        byte_done     = 1'b0;
        frame_err     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev && !rx_sync) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_next = '0;
                    rx_bit_next = '0;
                    rx_next     = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    rx_bit_next   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_ferr) begin
                    rx_cnt_next = '0;
                    if (rx_sync) begin
                        rx_ferr_next = 1'b0;
                        rx_next      = RX_IDLE;
                    end
                end else if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_sync) begin
                        byte_done = 1'b1;
                        rx_next   = RX_IDLE;
                    end else begin
                        frame_err    = 1'b1;
                        rx_ferr_next = 1'b1;
                    end
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Byte-assembly state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= WAIT_HI;
        end else begin
            asm_state <= asm_next;
        end
    end

    // Byte-assembly next state: a framing error realigns to the high byte
    always_comb begin
        asm_next = asm_state;
        if (frame_err) begin
            asm_next = WAIT_HI;
        end else if (byte_done) begin
            asm_next = (asm_state == WAIT_HI) ? WAIT_LO : WAIT_HI;
        end
    end

    // Command capture; completing low byte takes priority over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else if (byte_done && !frame_err && asm_state == WAIT_LO) begin
            cmd[7:0] <= rx_shift;
            cmd_rdy  <= 1'b1;
        end else if (byte_done && !frame_err && asm_state == WAIT_HI) begin
            cmd[15:8] <= rx_shift;
            cmd_rdy   <= 1'b0;
        end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
        end
    end

    // TX state, datapath and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_data  <= '0;
            TX       <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_data  <= tx_data_next;
            TX       <= tx_line_next;
        end
    end

    // TX next-state logic: each cell lasts BAUD_DIV cycles, line follows next state
    always_comb begin
        tx_next      = tx_state;
        tx_cnt_next  = tx_cnt + CW'(1);
        tx_bit_next  = tx_bit;
        tx_data_next = tx_data;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_next = '0;
                if (send_resp) begin
                    tx_data_next = resp;
                    tx_next      = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next = '0;
                    tx_bit_next = '0;
                    tx_next     = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit == 3'd7) begin
                        tx_next = TX_STOP;
                    end else begin
                        tx_bit_next = tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next = '0;
                    tx_next     = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
        case (tx_next)
            TX_START: tx_line_next = 1'b0;
            TX_DATA:  tx_line_next = tx_data_next[tx_bit_next];
            default:  tx_line_next = 1'b1;
        endcase
    end

    assign tx_busy   = (tx_state != TX_IDLE);
    assign resp_sent = (tx_state == TX_STOP) && (tx_cnt == BIT_LAST);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Testbench for uart_cmd_responder: table-driven full-duplex command/response
// vectors plus hand-written sequences, with queue-based scoreboards on both links.
module tb_uart_cmd_responder;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        tx_busy;
    logic        resp_sent;

    int errors = 0;
    int checks = 0;
    int resp_sent_cnt = 0;

    logic [15:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_cmd;
        logic [7:0]  rsp;
    } vec_t;

    vec_t vecs[4];

    uart_cmd_responder #(.BAUD_DIV(BAUD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RX(RX),
        .TX(TX),
        .cmd(cmd),
        .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp),
        .send_resp(send_resp),
        .tx_busy(tx_busy),
        .resp_sent(resp_sent)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the caller 1 time unit after a rising edge
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; entered and exited 1 unit after a rising edge
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        logic [9:0] cells;
        cells = {stop_val, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = cells[i];
            repeat (BAUD) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_send(input logic [7:0] r);
        resp = r;
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
    endtask

    task automatic wait_resp_sent();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (resp_sent) seen = 1;
        end
        if (!seen) checkOutput("resp_sent timeout", 0, 1);
        align();
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        checkOutput("cmd_rdy after clr", {31'd0, cmd_rdy}, 0);
    endtask

    // One full-duplex vector: a command in on RX while a response goes out on TX
    task automatic applyStimulus(input vec_t v);
        align();
        exp_cmd_q.push_back(v.exp_cmd);
        exp_tx_q.push_back(v.rsp);
        fork
            begin
                send_byte(v.hi, 1'b1);
                send_byte(v.lo, 1'b1);
            end
            begin
                pulse_send(v.rsp);
                wait_resp_sent();
            end
        join
        checkOutput("cmd_rdy set", {31'd0, cmd_rdy}, 1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("cmd_rdy held", {31'd0, cmd_rdy}, 1);
        checkOutput("cmd held", {16'd0, cmd}, {16'd0, v.exp_cmd});
        clear_cmd();
    endtask

    always @(negedge clk) begin
        if (resp_sent === 1'b1) resp_sent_cnt++;
    end

    // Command scoreboard: every rising cmd_rdy consumes one expected command
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (rst_n && cmd_rdy && !prev_rdy) begin
            if (exp_cmd_q.size() == 0) begin
                errors++;
                checks++;
                $display("[TB] FAIL unexpected cmd_rdy: got cmd 0x%0h, expected no command", cmd);
            end else begin
                checkOutput("scoreboard cmd", {16'd0, cmd}, {16'd0, exp_cmd_q.pop_front()});
            end
        end
        prev_rdy = cmd_rdy;
    end

    // Response scoreboard: decodes TX frames mid-cell, abandons a frame on reset
    initial begin
        logic       tx_prev;
        logic [9:0] cells;
        bit         abort;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && tx_prev && TX === 1'b0) begin
                abort = 0;
                for (int c = 0; c < 10 && !abort; c++) begin
                    for (int w = 0; w < ((c == 0) ? BAUD / 2 - 1 : BAUD) && !abort; w++) begin
                        @(negedge clk);
                        if (!rst_n) abort = 1;
                    end
                    cells[c] = TX;
                end
                if (!abort) begin
                    checkOutput("tx start bit", {31'd0, cells[0]}, 0);
                    checkOutput("tx stop bit", {31'd0, cells[9]}, 1);
                    if (exp_tx_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("[TB] FAIL unexpected tx frame: got 0x%0h, expected none", cells[8:1]);
                    end else begin
                        checkOutput("tx data", {24'd0, cells[8:1]}, {24'd0, exp_tx_q.pop_front()});
                    end
                end
            end
            tx_prev = rst_n ? TX : 1'b1;
        end
    end

    initial begin
        int first_k;
        int pulses;
        int rs_before;
        bit hit;

        vecs[0] = '{8'h43, 8'h01, 16'h4301, 8'h5C};
        vecs[1] = '{8'hA5, 8'h5A, 16'hA55A, 8'h00};
        vecs[2] = '{8'hFF, 8'h00, 16'hFF00, 8'hFF};
        vecs[3] = '{8'h00, 8'hFF, 16'h00FF, 8'h81};

        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset TX", {31'd0, TX}, 1);
        checkOutput("reset cmd", {16'd0, cmd}, 0);
        checkOutput("reset cmd_rdy", {31'd0, cmd_rdy}, 0);
        checkOutput("reset tx_busy", {31'd0, tx_busy}, 0);
        checkOutput("reset resp_sent", {31'd0, resp_sent}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) align();

        // Response 0xA5 with a cycle-accurate view and an ignored second request
        $display("[TB] response timing");
        exp_tx_q.push_back(8'hA5);
        align();
        pulse_send(8'hA5);
        first_k = 0;
        pulses = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput("tx start edge", {31'd0, TX}, 0);
                checkOutput("tx_busy on accept", {31'd0, tx_busy}, 1);
            end
            if (k == 50) begin
                resp = 8'h3C;
                send_resp = 1'b1;
            end
            if (k == 51) send_resp = 1'b0;
            if (k == 160) checkOutput("tx_busy in last stop cycle", {31'd0, tx_busy}, 1);
            if (k == 161) checkOutput("tx_busy after stop", {31'd0, tx_busy}, 0);
            if (resp_sent) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        checkOutput("resp_sent cycle", first_k, 160);
        checkOutput("resp_sent pulses", pulses, 1);

        // Table of full-duplex command/response vectors
        $display("[TB] vector table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
        end

        // Framing errors: discarded byte, and realignment after a valid high byte
        $display("[TB] framing error");
        align();
        exp_cmd_q.push_back(16'h4003);
        send_byte(8'h41, 1'b0);
        RX = 1'b1;
        repeat (20) align();
        send_byte(8'h77, 1'b1);
        send_byte(8'h41, 1'b0);
        RX = 1'b1;
        repeat (20) align();
        checkOutput("no cmd after framing error", {31'd0, cmd_rdy}, 0);
        send_byte(8'h40, 1'b1);
        send_byte(8'h03, 1'b1);
        checkOutput("framing cmd", {16'd0, cmd}, 32'h4003);
        checkOutput("framing cmd_rdy", {31'd0, cmd_rdy}, 1);
        clear_cmd();

        // Short RX glitch must not start a byte
        $display("[TB] glitch and back-to-back");
        align();
        RX = 1'b0;
        repeat (3) align();
        RX = 1'b1;
        repeat (40) align();
        checkOutput("glitch cmd_rdy", {31'd0, cmd_rdy}, 0);
        exp_cmd_q.push_back(16'h1234);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        checkOutput("post-glitch cmd", {16'd0, cmd}, 32'h1234);

        // Back-to-back commands without a clear; cmd_rdy drops on the next high byte
        exp_cmd_q.push_back(16'h0102);
        exp_cmd_q.push_back(16'h0304);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        checkOutput("b2b first cmd_rdy", {31'd0, cmd_rdy}, 1);
        send_byte(8'h03, 1'b1);
        checkOutput("b2b drop at byte 3", {31'd0, cmd_rdy}, 0);
        send_byte(8'h04, 1'b1);
        checkOutput("b2b final cmd", {16'd0, cmd}, 32'h0304);
        checkOutput("b2b final cmd_rdy", {31'd0, cmd_rdy}, 1);
        clear_cmd();

        // Clear coinciding with the completing low byte: set wins
        $display("[TB] set/clear collision");
        align();
        exp_cmd_q.push_back(16'h5678);
        send_byte(8'h56, 1'b1);
        hit = 0;
        fork
            send_byte(8'h78, 1'b1);
            begin
                for (int i = 0; i < 400 && !hit; i++) begin
                    @(negedge clk);
                    if (dut.byte_done) begin
                        hit = 1;
                        clr_cmd_rdy = 1'b1;
                        @(posedge clk);
                        #1;
                        clr_cmd_rdy = 1'b0;
                    end
                end
            end
        join
        checkOutput("collision seen", {31'd0, hit}, 1);
        checkOutput("collision cmd_rdy", {31'd0, cmd_rdy}, 1);
        checkOutput("collision cmd", {16'd0, cmd}, 32'h5678);
        clear_cmd();

        // Reset during a TX data bit abandons the frame
        $display("[TB] reset mid-transmit");
        align();
        pulse_send(8'hC3);
        repeat (40) align();
        rs_before = resp_sent_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid-reset TX", {31'd0, TX}, 1);
        checkOutput("mid-reset tx_busy", {31'd0, tx_busy}, 0);
        repeat (5) align();
        rst_n = 1'b1;
        repeat (200) align();
        checkOutput("no resp_sent after reset", resp_sent_cnt, rs_before);
        checkOutput("cmd cleared by reset", {16'd0, cmd}, 0);
        exp_tx_q.push_back(8'h5A);
        pulse_send(8'h5A);
        wait_resp_sent();
        checkOutput("post-reset resp_sent count", resp_sent_cnt, rs_before + 1);

        repeat (20) align();
        checkOutput("cmd queue drained", exp_cmd_q.size(), 0);
        checkOutput("tx queue drained", exp_tx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
